// File: rtl/ttl_counter_n_if.sv
// Bus bundle for ttl_counter_n: control inputs, load data, count state and ripple carry.
// UP exists only when COUNTER_UPDOWN_EN is defined.
interface ttl_counter_n_if #(
  parameter int WIDTH = 4
);
  logic             SCLR_N;
  logic             LOAD_N;
  logic             ENP;
  logic             ENT;
  logic [WIDTH-1:0] D;
`ifdef COUNTER_UPDOWN_EN
  logic             UP;
`endif
  logic [WIDTH-1:0] Q;
  logic             RCO;

  modport master (
`ifdef COUNTER_UPDOWN_EN
    output UP,
`endif
    output SCLR_N, LOAD_N, ENP, ENT, D,
    input  Q, RCO
  );

  modport slave (
`ifdef COUNTER_UPDOWN_EN
    input  UP,
`endif
    input  SCLR_N, LOAD_N, ENP, ENT, D,
    output Q, RCO
  );
endinterface

// File: rtl/ttl_counter_n.sv
// Presettable modulo-N counter in the 74x160/161/163 family with cascadable ENP/ENT and RCO.
// Define COUNTER_UPDOWN_EN to add the UP port, down counting and the down terminal compare.
module ttl_counter_n #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic         CLK,
  input  logic         CLR_N,
  ttl_counter_n_if.slave bus
);

  localparam logic [WIDTH-1:0] LAST   = WIDTH'(MODULUS - 1);
  localparam bit               BINARY = (MODULUS == (32'd1 << WIDTH));

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] upStep;
  logic             tcUp;
  logic             tc;

  // Out-of-range loaded values fold to zero on the next up count, same as the terminal value.
  always_comb begin
    if (BINARY) begin
      upStep = q_q + 1'b1;
    end else begin
      upStep = (q_q >= LAST) ? '0 : q_q + 1'b1;
    end
  end

  assign tcUp = (q_q == LAST);

`ifdef COUNTER_UPDOWN_EN
  logic [WIDTH-1:0] downStep;
  logic             tcDown;

  assign downStep = (q_q == '0) ? LAST : q_q - 1'b1;
  assign tcDown   = (q_q == '0);
  assign tc       = bus.UP ? tcUp : tcDown;
`else
  assign tc       = tcUp;
`endif

  always_comb begin
    q_d = q_q;
    if (!bus.SCLR_N) begin
      q_d = '0;
    end else if (!bus.LOAD_N) begin
      q_d = bus.D;
    end else if (bus.ENP && bus.ENT) begin
`ifdef COUNTER_UPDOWN_EN
      q_d = bus.UP ? upStep : downStep;
`else
      q_d = upStep;
`endif
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // RCO stays combinational so a cascaded stage sees its ENT in the same cycle.
  assign bus.Q   = q_q;
  assign bus.RCO = bus.ENT & tc;

endmodule

// File: tb/tb_ttl_counter_n.sv
// Self-checking bench for ttl_counter_n: binary, decade and two-stage cascaded instances.
// Directed scenarios plus randomized traffic checked against an arithmetic reference model.
module tb_ttl_counter_n;

  logic clk = 1'b0;
  logic rstB;
  logic rstD;
  logic rstC;
  bit   dirUp = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ttl_counter_n_if #(.WIDTH(4)) bb ();
  ttl_counter_n_if #(.WIDTH(4)) dd ();
  ttl_counter_n_if #(.WIDTH(4)) c0 ();
  ttl_counter_n_if #(.WIDTH(4)) c1 ();

  ttl_counter_n #(.WIDTH(4), .MODULUS(16)) dutB  (.CLK(clk), .CLR_N(rstB), .bus(bb.slave));
  ttl_counter_n #(.WIDTH(4), .MODULUS(10)) dutD  (.CLK(clk), .CLR_N(rstD), .bus(dd.slave));
  ttl_counter_n #(.WIDTH(4), .MODULUS(16)) dutC0 (.CLK(clk), .CLR_N(rstC), .bus(c0.slave));
  ttl_counter_n #(.WIDTH(4), .MODULUS(16)) dutC1 (.CLK(clk), .CLR_N(rstC), .bus(c1.slave));

  assign c1.ENT = c0.RCO;

`ifdef COUNTER_UPDOWN_EN
  assign bb.UP = dirUp;
  assign dd.UP = dirUp;
  assign c0.UP = 1'b1;
  assign c1.UP = 1'b1;
`endif

  function automatic int nextQ(int q, bit s, bit l, bit p, bit t, int d, bit u, int m);
    if (!s) return 0;
    if (!l) return d;
    if (!(p && t)) return q;
    if (u) return (q + 1 >= m) ? 0 : q + 1;
    return (q == 0) ? m - 1 : q - 1;
  endfunction

  function automatic bit expRco(int q, bit t, bit u, int m);
    return t && (u ? (q == m - 1) : (q == 0));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveB(input bit s, input bit l, input bit p, input bit t, input logic [3:0] d);
    bb.SCLR_N = s; bb.LOAD_N = l; bb.ENP = p; bb.ENT = t; bb.D = d;
  endtask

  task automatic driveD(input bit s, input bit l, input bit p, input bit t, input logic [3:0] d);
    dd.SCLR_N = s; dd.LOAD_N = l; dd.ENP = p; dd.ENT = t; dd.D = d;
  endtask

  task automatic test_reset();
    rstB = 1'b0; rstD = 1'b0; rstC = 1'b0;
    driveB(1, 1, 1, 1, 4'd0);
    driveD(1, 1, 1, 1, 4'd0);
    c0.SCLR_N = 1'b1; c0.LOAD_N = 1'b1; c0.ENP = 1'b1; c0.ENT = 1'b1; c0.D = 4'd0;
    c1.SCLR_N = 1'b1; c1.LOAD_N = 1'b1; c1.ENP = 1'b1; c1.D = 4'd0;
    #12;
    checks++;
    if (bb.Q !== 4'd0) begin failures++; $display("[TB] FAIL reset_qB got=%0d exp=0", bb.Q); end
    checks++;
    if (dd.Q !== 4'd0) begin failures++; $display("[TB] FAIL reset_qD got=%0d exp=0", dd.Q); end
    checks++;
    if ({c1.Q, c0.Q} !== 8'd0) begin failures++; $display("[TB] FAIL reset_qC got=%0d exp=0", {c1.Q, c0.Q}); end
    checks++;
    if (bb.RCO !== 1'b0) begin failures++; $display("[TB] FAIL reset_rcoB got=%b exp=0", bb.RCO); end
    checks++;
    if (dd.RCO !== 1'b0) begin failures++; $display("[TB] FAIL reset_rcoD got=%b exp=0", dd.RCO); end
  endtask

  task automatic test_binary_wrap();
    int expQ = 0;
    @(negedge clk);
    rstB = 1'b1;
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (bb.RCO !== (expQ == 15)) begin
        failures++; $display("[TB] FAIL wrap_rco step=%0d got=%b exp=%b", i, bb.RCO, expQ == 15);
      end
      tick();
      expQ = (expQ + 1) % 16;
      checks++;
      if (bb.Q !== 4'(expQ)) begin
        failures++; $display("[TB] FAIL wrap_q step=%0d got=%0d exp=%0d", i, bb.Q, expQ);
      end
    end
  endtask

  task automatic test_decade_load();
    @(negedge clk);
    rstD = 1'b1;
    driveD(1, 0, 1, 1, 4'd12);
    tick();
    checks++;
    if (dd.Q !== 4'd12) begin failures++; $display("[TB] FAIL load12_q got=%0d exp=12", dd.Q); end
    checks++;
    if (dd.RCO !== 1'b0) begin failures++; $display("[TB] FAIL load12_rco got=%b exp=0", dd.RCO); end
    driveD(1, 1, 1, 1, 4'd0);
    tick();
    checks++;
    if (dd.Q !== 4'd0) begin failures++; $display("[TB] FAIL oor_wrap_q got=%0d exp=0", dd.Q); end
    driveD(1, 0, 1, 1, 4'd9);
    tick();
    driveD(1, 1, 1, 1, 4'd0);
    #1;
    checks++;
    if (dd.RCO !== 1'b1) begin failures++; $display("[TB] FAIL tc9_rco_ent1 got=%b exp=1", dd.RCO); end
    driveD(1, 1, 1, 0, 4'd0);
    #1;
    checks++;
    if (dd.RCO !== 1'b0) begin failures++; $display("[TB] FAIL tc9_rco_ent0 got=%b exp=0", dd.RCO); end
  endtask

  task automatic test_priority();
    driveD(1, 0, 0, 0, 4'd7);
    tick();
    checks++;
    if (dd.Q !== 4'd7) begin failures++; $display("[TB] FAIL prio_setup got=%0d exp=7", dd.Q); end
    driveD(0, 0, 1, 1, 4'd5);
    tick();
    checks++;
    if (dd.Q !== 4'd0) begin failures++; $display("[TB] FAIL prio_clear got=%0d exp=0", dd.Q); end
    driveD(1, 0, 1, 1, 4'd5);
    tick();
    checks++;
    if (dd.Q !== 4'd5) begin failures++; $display("[TB] FAIL prio_load got=%0d exp=5", dd.Q); end
    driveD(1, 1, 0, 1, 4'd5);
    tick();
    checks++;
    if (dd.Q !== 4'd5) begin failures++; $display("[TB] FAIL prio_hold got=%0d exp=5", dd.Q); end
  endtask

  task automatic test_async_clear();
    driveB(1, 0, 1, 1, 4'd11);
    tick();
    checks++;
    if (bb.Q !== 4'd11) begin failures++; $display("[TB] FAIL aclr_setup got=%0d exp=11", bb.Q); end
    driveB(1, 1, 1, 1, 4'd0);
    #2;
    rstB = 1'b0;
    #1;
    checks++;
    if (bb.Q !== 4'd0) begin failures++; $display("[TB] FAIL aclr_immediate got=%0d exp=0", bb.Q); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bb.Q !== 4'd0) begin failures++; $display("[TB] FAIL aclr_hold edge=%0d got=%0d exp=0", i, bb.Q); end
    end
    @(negedge clk);
    rstB = 1'b1;
    tick();
    checks++;
    if (bb.Q !== 4'd1) begin failures++; $display("[TB] FAIL aclr_release got=%0d exp=1", bb.Q); end
  endtask

  task automatic test_cascade();
    int expC = 0;
    @(negedge clk);
    rstC = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tick();
      expC = (expC + 1) % 256;
      checks++;
      if ({c1.Q, c0.Q} !== 8'(expC)) begin
        failures++; $display("[TB] FAIL cascade step=%0d got=%0d exp=%0d", i, {c1.Q, c0.Q}, expC);
      end
    end
  endtask

`ifdef COUNTER_UPDOWN_EN
  task automatic test_updown();
    dirUp = 1'b0;
    driveD(0, 1, 1, 1, 4'd0);
    tick();
    driveD(1, 1, 1, 1, 4'd0);
    #1;
    checks++;
    if (dd.RCO !== 1'b1) begin failures++; $display("[TB] FAIL down_rco0 got=%b exp=1", dd.RCO); end
    for (int v = 9; v >= 3; v--) begin
      tick();
      checks++;
      if (dd.Q !== 4'(v)) begin failures++; $display("[TB] FAIL down_q got=%0d exp=%0d", dd.Q, v); end
    end
    dirUp = 1'b1;
    tick();
    checks++;
    if (dd.Q !== 4'd4) begin failures++; $display("[TB] FAIL dir_switch got=%0d exp=4", dd.Q); end
  endtask
`endif

  task automatic test_random();
    int qB = 0;
    int qD = 0;
    bit sB, lB, pB, tB, sD, lD, pD, tD;
    int dB, dD;
    driveB(0, 1, 0, 0, 4'd0);
    driveD(0, 1, 0, 0, 4'd0);
    tick();
    for (int i = 0; i < 400; i++) begin
      sB = ($urandom_range(0, 9) != 0); lB = ($urandom_range(0, 4) != 0);
      pB = ($urandom_range(0, 3) != 0); tB = ($urandom_range(0, 3) != 0);
      dB = $urandom_range(0, 15);
      sD = ($urandom_range(0, 9) != 0); lD = ($urandom_range(0, 4) != 0);
      pD = ($urandom_range(0, 3) != 0); tD = ($urandom_range(0, 3) != 0);
      dD = $urandom_range(0, 15);
`ifdef COUNTER_UPDOWN_EN
      dirUp = 1'($urandom_range(0, 1));
`endif
      driveB(sB, lB, pB, tB, 4'(dB));
      driveD(sD, lD, pD, tD, 4'(dD));
      #1;
      checks++;
      if (bb.RCO !== expRco(qB, tB, dirUp, 16)) begin
        failures++; $display("[TB] FAIL rand_rcoB cyc=%0d got=%b exp=%b", i, bb.RCO, expRco(qB, tB, dirUp, 16));
      end
      checks++;
      if (dd.RCO !== expRco(qD, tD, dirUp, 10)) begin
        failures++; $display("[TB] FAIL rand_rcoD cyc=%0d got=%b exp=%b", i, dd.RCO, expRco(qD, tD, dirUp, 10));
      end
      tick();
      qB = nextQ(qB, sB, lB, pB, tB, dB, dirUp, 16);
      qD = nextQ(qD, sD, lD, pD, tD, dD, dirUp, 10);
      checks++;
      if (bb.Q !== 4'(qB)) begin failures++; $display("[TB] FAIL rand_qB cyc=%0d got=%0d exp=%0d", i, bb.Q, qB); end
      checks++;
      if (dd.Q !== 4'(qD)) begin failures++; $display("[TB] FAIL rand_qD cyc=%0d got=%0d exp=%0d", i, dd.Q, qD); end
    end
  endtask

  initial begin
    test_reset();
    test_binary_wrap();
    test_decade_load();
    test_priority();
    test_async_clear();
    test_cascade();
`ifdef COUNTER_UPDOWN_EN
    test_updown();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
